// File: rtl/pp_mult_pkg.sv
// ---------------------------------------------------------------------------
// pp_mult_pkg
// Shared constants and types for the 8x8 partial-product multiplier path.
// The processing-block wrappers and the final carry-propagate stage both
// import this package so that row, product and tag widths agree everywhere.
//   PP_ROW_W  : width of each reduced row leaving the compressor tree
//   PP_PROD_W : width of the final product
//   PP_SEG_W  : width of the low carry segment in the final adder
//   PP_TAG_W  : width of the sideband tag travelling with each operand pair
//   pp_rows_t : one reduced row pair plus its tag
// ---------------------------------------------------------------------------
package pp_mult_pkg;

  localparam int PP_ROW_W  = 15;
  localparam int PP_PROD_W = 16;
  localparam int PP_SEG_W  = 8;
  localparam int PP_TAG_W  = 4;

  typedef struct packed {
    logic [PP_ROW_W-1:0] row1;
    logic [PP_ROW_W-1:0] row2;
    logic [PP_TAG_W-1:0] tag;
  } pp_rows_t;

endpackage

// File: rtl/seg_adder.sv
// ---------------------------------------------------------------------------
// seg_adder
// Purely combinational WIDTH-bit adder with carry-in and carry-out. Each
// pipeline stage of the final adder uses one instance, so the critical path
// of a stage is a single segment-wide ripple add.
// Ports:
//   a_i, b_i  : addends, WIDTH bits
//   cin_i     : carry into bit 0
//   sum_o     : WIDTH-bit sum
//   cout_o    : carry out of the top bit
// ---------------------------------------------------------------------------
module seg_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  // Widen everything by one bit so the carry-out falls out of the add itself.
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/pp_final_adder_8.sv
// ---------------------------------------------------------------------------
// pp_final_adder_8
// Two-stage pipelined carry-propagate adder that turns the two reduced rows
// of the 8x8 partial-product tree into the final product. Stage 1 adds the
// low SEG_W bits and registers the sum, its carry and the untouched high row
// segments; stage 2 adds the high segments plus that carry and registers the
// full product. A valid/ready handshake with full back-pressure lets it run
// at one product per cycle.
// Ports:
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready  : input handshake for a row pair
//   row1, row2, in_tag  : reduced rows and their sideband tag
//   out_valid, out_ready: output handshake for a product
//   product, out_tag    : row1 + row2 (ROW_W+1 bits) and the matching tag
// ---------------------------------------------------------------------------
module pp_final_adder_8
  import pp_mult_pkg::*;
#(
  parameter int ROW_W = PP_ROW_W,
  parameter int SEG_W = PP_SEG_W,
  parameter int TAG_W = PP_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROW_W-1:0] row1,
  input  logic [ROW_W-1:0] row2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W:0]   product,
  output logic [TAG_W-1:0] out_tag
);

  localparam int HI_W = ROW_W - SEG_W;

  // Stage 1 registers
  logic             s1Valid_q, s1Valid_d;
  logic [SEG_W-1:0] s1Lo_q, s1Lo_d;
  logic             s1Carry_q, s1Carry_d;
  logic [HI_W-1:0]  s1Hi1_q, s1Hi1_d;
  logic [HI_W-1:0]  s1Hi2_q, s1Hi2_d;
  logic [TAG_W-1:0] s1Tag_q, s1Tag_d;

  // Stage 2 registers
  logic             s2Valid_q, s2Valid_d;
  logic [ROW_W:0]   s2Prod_q, s2Prod_d;
  logic [TAG_W-1:0] s2Tag_q, s2Tag_d;

  // Handshake and adder results
  logic             s2Adv;
  logic             s1Adv;
  logic             inFire;
  logic [SEG_W-1:0] loSum;
  logic             loCarry;
  logic [HI_W-1:0]  hiSum;
  logic             hiCarry;

  // Low segment is added straight off the input rows.
  seg_adder #(.WIDTH(SEG_W)) loAdder (
    .a_i   (row1[SEG_W-1:0]),
    .b_i   (row2[SEG_W-1:0]),
    .cin_i (1'b0),
    .sum_o (loSum),
    .cout_o(loCarry)
  );

  // High segment works on the registered halves plus the registered carry.
  seg_adder #(.WIDTH(HI_W)) hiAdder (
    .a_i   (s1Hi1_q),
    .b_i   (s1Hi2_q),
    .cin_i (s1Carry_q),
    .sum_o (hiSum),
    .cout_o(hiCarry)
  );

  // S2 can take new data when it is empty or its product leaves this cycle;
  // in_ready is therefore combinational from out_ready, which is deliberate.
  always_comb begin
    s2Adv    = !s2Valid_q || out_ready;
    s1Adv    = s1Valid_q && s2Adv;
    in_ready = !s1Valid_q || s2Adv;
    inFire   = in_valid && in_ready;
  end

  // Stage 1 next state: a new load wins over a drain, which is what makes
  // load-and-move in the same cycle stream without bubbles.
  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Lo_d    = s1Lo_q;
    s1Carry_d = s1Carry_q;
    s1Hi1_d   = s1Hi1_q;
    s1Hi2_d   = s1Hi2_q;
    s1Tag_d   = s1Tag_q;
    if (inFire) begin
      s1Valid_d = 1'b1;
      s1Lo_d    = loSum;
      s1Carry_d = loCarry;
      s1Hi1_d   = row1[ROW_W-1:SEG_W];
      s1Hi2_d   = row2[ROW_W-1:SEG_W];
      s1Tag_d   = in_tag;
    end else if (s1Adv) begin
      s1Valid_d = 1'b0;
    end
  end

  // Stage 2 next state: an incoming pair from S1 wins over a pop, so a pop
  // and a reload in the same cycle keep the output valid.
  always_comb begin
    s2Valid_d = s2Valid_q;
    s2Prod_d  = s2Prod_q;
    s2Tag_d   = s2Tag_q;
    if (s1Adv) begin
      s2Valid_d = 1'b1;
      s2Prod_d  = {hiCarry, hiSum, s1Lo_q};
      s2Tag_d   = s1Tag_q;
    end else if (s2Valid_q && out_ready) begin
      s2Valid_d = 1'b0;
    end
  end

  // Pipeline registers; reset clears all data so nothing stale can leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Lo_q    <= '0;
      s1Carry_q <= 1'b0;
      s1Hi1_q   <= '0;
      s1Hi2_q   <= '0;
      s1Tag_q   <= '0;
      s2Valid_q <= 1'b0;
      s2Prod_q  <= '0;
      s2Tag_q   <= '0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Lo_q    <= s1Lo_d;
      s1Carry_q <= s1Carry_d;
      s1Hi1_q   <= s1Hi1_d;
      s1Hi2_q   <= s1Hi2_d;
      s1Tag_q   <= s1Tag_d;
      s2Valid_q <= s2Valid_d;
      s2Prod_q  <= s2Prod_d;
      s2Tag_q   <= s2Tag_d;
    end
  end

  // Outputs come straight from stage 2 so they are glitch-free and stable.
  always_comb begin
    out_valid = s2Valid_q;
    product   = s2Prod_q;
    out_tag   = s2Tag_q;
  end

endmodule

// File: tb/tb_pp_final_adder_8.sv
// ---------------------------------------------------------------------------
// tb_pp_final_adder_8
// Directed and random stimulus for the two-stage final adder. Every accepted
// pair pushes its expected product and tag into a queue; every popped output
// is compared against the head of that queue, so ordering, loss and
// duplication are all caught alongside the arithmetic.
// ---------------------------------------------------------------------------
module tb_pp_final_adder_8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] row1;
  logic [14:0] row2;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic [3:0]  out_tag;

  int vectorCount;
  int errorCount;
  int popCount;

  logic [15:0] expProdQ[$];
  logic [3:0]  expTagQ[$];

  pp_final_adder_8 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .row1     (row1),
    .row2     (row2),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .out_tag  (out_tag)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, settle, log handshakes against the
  // scoreboard, then advance to just after the next rising edge
  task automatic applyStimulus(input logic iv, input logic [14:0] r1,
                               input logic [14:0] r2, input logic [3:0] tg,
                               input logic [15:0] expP, input logic ordy,
                               output logic accepted);
    in_valid  = iv;
    row1      = r1;
    row2      = r2;
    in_tag    = tg;
    out_ready = ordy;
    #1;
    accepted = iv && in_ready;
    if (out_valid && out_ready) begin
      if (expProdQ.size() == 0) begin
        checkOutput("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        checkOutput("product", {16'd0, product}, {16'd0, expProdQ.pop_front()});
        checkOutput("out_tag", {28'd0, out_tag}, {28'd0, expTagQ.pop_front()});
        popCount++;
      end
    end
    if (accepted) begin
      expProdQ.push_back(expP);
      expTagQ.push_back(tg);
    end
    @(posedge clk);
    #1;
  endtask

  // Keep offering one pair until it is taken, with a bounded wait
  task automatic offerItem(input logic [14:0] r1, input logic [14:0] r2,
                           input logic [3:0] tg, input logic [15:0] expP,
                           input logic ordy);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      applyStimulus(1'b1, r1, r2, tg, expP, ordy, acc);
      tries++;
    end
    if (!acc) checkOutput("offer_timeout", {31'd0, acc}, 32'd1);
  endtask

  // Empty the pipe with out_ready high, bounded by a cycle budget
  task automatic drainPipe(input int maxCycles);
    logic acc;
    int   n;
    n = 0;
    while (expProdQ.size() != 0 && n < maxCycles) begin
      applyStimulus(1'b0, 15'd0, 15'd0, 4'd0, 16'd0, 1'b1, acc);
      n++;
    end
    checkOutput("drain_left", expProdQ.size(), 32'd0);
  endtask

  // Split a*b into two rows the way the reduction tree might: row2 even,
  // both rows within 15 bits, so row1 + row2 reconstructs the product
  task automatic mulRows(input logic [7:0] a, input logic [7:0] b,
                         output logic [14:0] r1, output logic [14:0] r2);
    logic [15:0] p;
    logic [15:0] half;
    p    = 16'(a) * 16'(b);
    half = (p >> 1) & 16'hFFFE;
    r2   = half[14:0];
    r1   = 15'(p - half);
  endtask

  // Main sequence
  initial begin
    logic [7:0]  mulA[16];
    logic [7:0]  mulB[16];
    logic [15:0] mulP[16];
    logic [14:0] r1;
    logic [14:0] r2;
    logic        acc;
    int          stalls;
    int          popStart;
    int          accCount;

    vectorCount = 0;
    errorCount  = 0;
    popCount    = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    row1        = '0;
    row2        = '0;
    in_tag      = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_product", {16'd0, product}, 32'd0);
    checkOutput("rst_out_tag", {28'd0, out_tag}, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Carry across the segment boundary, with latency checked by hand
    applyStimulus(1'b1, 15'h00FF, 15'h0001, 4'd3, 16'h0100, 1'b0, acc);
    checkOutput("lat_accept", {31'd0, acc}, 32'd1);
    checkOutput("lat_not_yet", {31'd0, out_valid}, 32'd0);
    applyStimulus(1'b0, 15'd0, 15'd0, 4'd0, 16'd0, 1'b0, acc);
    checkOutput("lat_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("carry_product", {16'd0, product}, 32'h0100);
    checkOutput("carry_tag", {28'd0, out_tag}, 32'd3);
    drainPipe(10);

    // Maximum operands
    offerItem(15'h7FFF, 15'h7FFF, 4'd5, 16'hFFFE, 1'b1);
    offerItem(15'h7FFF, 15'h0001, 4'd6, 16'h8000, 1'b1);
    drainPipe(10);

    // Streaming a*b products back to back; hand-computed references
    mulA = '{8'd0, 8'd255, 8'd1, 8'd255, 8'd16, 8'd128, 8'd200, 8'd12,
             8'd170, 8'd255, 8'd129, 8'd3, 8'd99, 8'd240, 8'd17, 8'd64};
    mulB = '{8'd0, 8'd255, 8'd1, 8'd1, 8'd16, 8'd2, 8'd100, 8'd13,
             8'd85, 8'd128, 8'd254, 8'd7, 8'd99, 8'd15, 8'd255, 8'd64};
    mulP = '{16'h0000, 16'hFE01, 16'h0001, 16'h00FF, 16'h0100, 16'h0100,
             16'h4E20, 16'h009C, 16'h3872, 16'h7F80, 16'h7FFE, 16'h0015,
             16'h2649, 16'h0E10, 16'h10EF, 16'h1000};
    stalls   = 0;
    popStart = popCount;
    for (int i = 0; i < 16; i++) begin
      mulRows(mulA[i], mulB[i], r1, r2);
      applyStimulus(1'b1, r1, r2, 4'(i), mulP[i], 1'b1, acc);
      if (!acc) stalls++;
    end
    repeat (2) applyStimulus(1'b0, 15'd0, 15'd0, 4'd0, 16'd0, 1'b1, acc);
    checkOutput("stream_stalls", stalls, 32'd0);
    checkOutput("stream_outputs", popCount - popStart, 32'd16);
    drainPipe(10);

    // Back-pressure: four pairs offered while the consumer stalls
    accCount = 0;
    for (int i = 0; i < 5; i++) begin
      case (accCount)
        0: applyStimulus(1'b1, 15'h1234, 15'h0F0F, 4'd8, 16'h2143, 1'b0, acc);
        1: applyStimulus(1'b1, 15'h4000, 15'h4000, 4'd9, 16'h8000, 1'b0, acc);
        default: applyStimulus(1'b1, 15'h0AAA, 15'h5555, 4'd10, 16'h5FFF, 1'b0, acc);
      endcase
      if (acc) accCount++;
      if (i >= 1) begin
        checkOutput("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_hold_product", {16'd0, product}, 32'h2143);
        checkOutput("bp_hold_tag", {28'd0, out_tag}, 32'd8);
      end
    end
    checkOutput("bp_accepted", accCount, 32'd2);
    checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
    popStart = popCount;
    offerItem(15'h0AAA, 15'h5555, 4'd10, 16'h5FFF, 1'b1);
    offerItem(15'h7FFE, 15'h0003, 4'd11, 16'h8001, 1'b1);
    drainPipe(10);
    checkOutput("bp_outputs", popCount - popStart, 32'd4);

    // Reset with the pipe full: outputs must drop without a clock edge
    offerItem(15'h0101, 15'h0202, 4'd1, 16'h0303, 1'b0);
    offerItem(15'h0404, 15'h0505, 4'd2, 16'h0909, 1'b0);
    checkOutput("full_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_product", {16'd0, product}, 32'd0);
    expProdQ.delete();
    expTagQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (4) applyStimulus(1'b0, 15'd0, 15'd0, 4'd0, 16'd0, 1'b1, acc);
    checkOutput("post_rst_idle", {31'd0, out_valid}, 32'd0);

    // Random traffic: hold each pair until accepted, model is plain addition
    begin
      logic [14:0] rr1;
      logic [14:0] rr2;
      logic [3:0]  rtg;
      rr1 = 15'($urandom);
      rr2 = 15'($urandom);
      rtg = 4'($urandom);
      for (int i = 0; i < 10000; i++) begin
        applyStimulus(1'($urandom_range(0, 1)), rr1, rr2, rtg,
                      16'(rr1) + 16'(rr2), 1'($urandom_range(0, 1)), acc);
        if (acc) begin
          rr1 = 15'($urandom);
          rr2 = 15'($urandom);
          rtg = 4'($urandom);
        end
      end
    end
    drainPipe(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
    $finish;
  end

endmodule
